edge_sequencer: RTL and testbench

Sequencer that time-shares one `edge_function` instance to perform a full triangle coverage test for one pixel. Per request it issues up to four edge evaluations: triangle area, then barycentric weights w0, w1, w2. It classifies the pixel as inside or outside and returns the raw float32 results. It sits between the rasterizer's pixel walker and the shared `edge_function` datapath, and owns that datapath's strobe handshake.

---
 rtl/edge_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_edge_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_sequencer.sv
// edge_sequencer: drives one shared edge_function datapath through the four
// edge evaluations of a pixel coverage test (area, w0, w1, w2). It classifies
// the pixel as inside or outside and returns the raw float32 results.
module edge_sequencer #(
  parameter bit          BOTH_WINDINGS  = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1024
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0][31:0] v0_i,
  input  logic [1:0][31:0] v1_i,
  input  logic [1:0][31:0] v2_i,
  input  logic [1:0][31:0] p_i,
  output logic             ready_o,
  output logic             done_o,
  output logic             inside_o,
  output logic             degenerate_o,
  output logic             error_o,
  output logic [31:0]      area_o,
  output logic [31:0]      w0_o,
  output logic [31:0]      w1_o,
  output logic [31:0]      w2_o,
  output logic [1:0][31:0] ef_a_o,
  output logic [1:0][31:0] ef_b_o,
  output logic [1:0][31:0] ef_c_o,
  output logic             ef_exec_strobe_o,
  input  logic [31:0]      ef_z_i,
  input  logic             ef_done_strobe_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0][31:0] a;
    logic [1:0][31:0] b;
    logic [1:0][31:0] c;
  } ef_ops_t;

  // The watchdog is compiled out of the decision when TIMEOUT_CYCLES is 0.
  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [31:0] WD_LAST = TIMEOUT_CYCLES - 32'd1;

  // Magnitude bits all zero: +0 or -0.
  function automatic logic f32_is_zero(input logic [31:0] x);
    return (x[30:0] == 31'd0);
  endfunction

  // -0 counts as on-edge, so it is both non-negative and non-positive.
  function automatic logic f32_non_neg(input logic [31:0] x);
    return (!x[31]) || f32_is_zero(x);
  endfunction

  function automatic logic f32_non_pos(input logic [31:0] x);
    return x[31] || f32_is_zero(x);
  endfunction

  // Coverage decision from the signs of the area and the three weights.
  function automatic logic coverage(input logic [31:0] area,
                                    input logic [31:0] w0,
                                    input logic [31:0] w1,
                                    input logic [31:0] w2);
    logic ccw;
    logic cw;
    ccw = f32_non_neg(area) && f32_non_neg(w0) && f32_non_neg(w1) && f32_non_neg(w2);
    cw  = BOTH_WINDINGS && area[31] &&
          f32_non_pos(w0) && f32_non_pos(w1) && f32_non_pos(w2);
    return ccw || cw;
  endfunction

  // Operand routing for each evaluation: area, then w0, w1, w2.
  function automatic ef_ops_t op_operands(input logic [1:0]       op,
                                          input logic [1:0][31:0] v0,
                                          input logic [1:0][31:0] v1,
                                          input logic [1:0][31:0] v2,
                                          input logic [1:0][31:0] p);
    ef_ops_t ops;
    case (op)
      2'd0: begin
        ops.a = v0; ops.b = v1; ops.c = v2;
      end
      2'd1: begin
        ops.a = v1; ops.b = v2; ops.c = p;
      end
      2'd2: begin
        ops.a = v2; ops.b = v0; ops.c = p;
      end
      default: begin
        ops.a = v0; ops.b = v1; ops.c = p;
      end
    endcase
    return ops;
  endfunction

  state_t           r_state;
  logic [1:0]       r_op;
  logic [31:0]      r_wdog;
  logic [1:0][31:0] r_v0;
  logic [1:0][31:0] r_v1;
  logic [1:0][31:0] r_v2;
  logic [1:0][31:0] r_p;
  logic             r_ready;
  logic             r_done;
  logic             r_inside;
  logic             r_degenerate;
  logic             r_error;
  logic [31:0]      r_area;
  logic [31:0]      r_w0;
  logic [31:0]      r_w1;
  logic [31:0]      r_w2;
  logic [1:0][31:0] r_ef_a;
  logic [1:0][31:0] r_ef_b;
  logic [1:0][31:0] r_ef_c;
  logic             r_strobe;

  ef_ops_t          w_start_ops;
  ef_ops_t          w_next_ops;
  logic [1:0]       w_next_op;
  logic             w_last_cover;

  // op0 operands come straight from the inputs so they are valid in the
  // first ISSUE cycle; later ops use the latched request.
  assign w_start_ops  = op_operands(2'd0, v0_i, v1_i, v2_i, p_i);
  assign w_next_op    = r_op + 2'd1;
  assign w_next_ops   = op_operands(w_next_op, r_v0, r_v1, r_v2, r_p);
  // w2 is the result arriving now; the decision is still captured in a register.
  assign w_last_cover = coverage(r_area, r_w0, r_w1, ef_z_i);

  // Sequencer FSM: request latch, strobe handshake, watchdog and result capture.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_op         <= 2'd0;
      r_wdog       <= 32'd0;
      r_v0         <= '0;
      r_v1         <= '0;
      r_v2         <= '0;
      r_p          <= '0;
      r_ready      <= 1'b1;
      r_done       <= 1'b0;
      r_inside     <= 1'b0;
      r_degenerate <= 1'b0;
      r_error      <= 1'b0;
      r_area       <= 32'd0;
      r_w0         <= 32'd0;
      r_w1         <= 32'd0;
      r_w2         <= 32'd0;
      r_ef_a       <= '0;
      r_ef_b       <= '0;
      r_ef_c       <= '0;
      r_strobe     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_v0         <= v0_i;
            r_v1         <= v1_i;
            r_v2         <= v2_i;
            r_p          <= p_i;
            r_op         <= 2'd0;
            r_inside     <= 1'b0;
            r_degenerate <= 1'b0;
            r_error      <= 1'b0;
            r_area       <= 32'd0;
            r_w0         <= 32'd0;
            r_w1         <= 32'd0;
            r_w2         <= 32'd0;
            r_ready      <= 1'b0;
            r_ef_a       <= w_start_ops.a;
            r_ef_b       <= w_start_ops.b;
            r_ef_c       <= w_start_ops.c;
            r_strobe     <= 1'b1;
            r_state      <= S_ISSUE;
          end else begin
            r_ready <= 1'b1;
          end
        end

        S_ISSUE: begin
          r_strobe <= 1'b0;
          r_wdog   <= 32'd0;
          r_state  <= S_WAIT;
        end

        S_WAIT: begin
          if (ef_done_strobe_i) begin
            case (r_op)
              2'd0:    r_area <= ef_z_i;
              2'd1:    r_w0   <= ef_z_i;
              2'd2:    r_w1   <= ef_z_i;
              default: r_w2   <= ef_z_i;
            endcase
            if ((r_op == 2'd0) && f32_is_zero(ef_z_i)) begin
              // Zero area: weights are meaningless, stop after one op.
              r_degenerate <= 1'b1;
              r_done       <= 1'b1;
              r_state      <= S_FINISH;
            end else if (r_op != 2'd3) begin
              r_op     <= w_next_op;
              r_ef_a   <= w_next_ops.a;
              r_ef_b   <= w_next_ops.b;
              r_ef_c   <= w_next_ops.c;
              r_strobe <= 1'b1;
              r_state  <= S_ISSUE;
            end else begin
              r_inside <= w_last_cover;
              r_done   <= 1'b1;
              r_state  <= S_FINISH;
            end
          end else if (WD_EN && (r_wdog == WD_LAST)) begin
            // Datapath never answered; any late done lands outside WAIT.
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_wdog <= r_wdog + 32'd1;
          end
        end

        S_FINISH: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_done   <= 1'b0;
          r_strobe <= 1'b0;
          r_ready  <= 1'b1;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o          = r_ready;
  assign done_o           = r_done;
  assign inside_o         = r_inside;
  assign degenerate_o     = r_degenerate;
  assign error_o          = r_error;
  assign area_o           = r_area;
  assign w0_o             = r_w0;
  assign w1_o             = r_w1;
  assign w2_o             = r_w2;
  assign ef_a_o           = r_ef_a;
  assign ef_b_o           = r_ef_b;
  assign ef_c_o           = r_ef_c;
  assign ef_exec_strobe_o = r_strobe;

endmodule

// File: tb/tb_edge_sequencer.sv
// Bench for edge_sequencer: an edge_function stub with programmable latency,
// and a real-arithmetic coverage model. It runs directed and random requests
// on a single-winding instance (short watchdog) and a both-windings instance.
module tb_edge_sequencer;

  localparam logic [31:0] Z    = 32'h00000000;
  localparam logic [31:0] ONE  = 32'h3f800000;
  localparam logic [31:0] HALF = 32'h3f000000;
  localparam logic [31:0] QTR  = 32'h3e800000;
  localparam logic [31:0] TWO  = 32'h40000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_i = 1'b0;
  logic             start_i = 1'b0;
  logic [1:0][31:0] v0_i = '0, v1_i = '0, v2_i = '0, p_i = '0;
  logic [31:0]      ef_z = 32'd0;
  logic             ef_done = 1'b0;

  logic             ready_a, done_a, inside_a, degen_a, err_a, strobe_a;
  logic [31:0]      area_a, w0_a, w1_a, w2_a;
  logic [1:0][31:0] efa_a, efb_a, efc_a;
  logic             ready_b, done_b, inside_b, degen_b, err_b, strobe_b;
  logic [31:0]      area_b, w0_b, w1_b, w2_b;
  logic [1:0][31:0] efa_b, efb_b, efc_b;

  edge_sequencer #(.BOTH_WINDINGS(1'b0), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .reset_i(reset_i), .start_i(start_i),
    .v0_i(v0_i), .v1_i(v1_i), .v2_i(v2_i), .p_i(p_i),
    .ready_o(ready_a), .done_o(done_a), .inside_o(inside_a),
    .degenerate_o(degen_a), .error_o(err_a),
    .area_o(area_a), .w0_o(w0_a), .w1_o(w1_a), .w2_o(w2_a),
    .ef_a_o(efa_a), .ef_b_o(efb_a), .ef_c_o(efc_a),
    .ef_exec_strobe_o(strobe_a), .ef_z_i(ef_z), .ef_done_strobe_i(ef_done)
  );

  edge_sequencer #(.BOTH_WINDINGS(1'b1), .TIMEOUT_CYCLES(1024)) dut_b (
    .clk(clk), .reset_i(reset_i), .start_i(start_i),
    .v0_i(v0_i), .v1_i(v1_i), .v2_i(v2_i), .p_i(p_i),
    .ready_o(ready_b), .done_o(done_b), .inside_o(inside_b),
    .degenerate_o(degen_b), .error_o(err_b),
    .area_o(area_b), .w0_o(w0_b), .w1_o(w1_b), .w2_o(w2_b),
    .ef_a_o(efa_b), .ef_b_o(efb_b), .ef_c_o(efc_b),
    .ef_exec_strobe_o(strobe_b), .ef_z_i(ef_z), .ef_done_strobe_i(ef_done)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // float32 <-> real for normal numbers and signed zero (enough for test data)
  function automatic real f2r(input logic [31:0] b);
    logic [10:0] e64;
    if (b[30:0] == 31'd0) return b[31] ? $bitstoreal(64'h8000000000000000) : 0.0;
    e64 = 11'(b[30:23]) + 11'd896;
    return $bitstoreal({b[31], e64, b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e64;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e64 = d[62:52] - 11'd896;
    return {d[63], e64[7:0], d[51:29]};
  endfunction

  function automatic real edge_e(input logic [1:0][31:0] a, b, c);
    return (f2r(c[0]) - f2r(a[0])) * (f2r(b[1]) - f2r(a[1]))
         - (f2r(c[1]) - f2r(a[1])) * (f2r(b[0]) - f2r(a[0]));
  endfunction

  function automatic logic [1:0][31:0] pt(input logic [31:0] x, input logic [31:0] y);
    return {y, x};
  endfunction

  // edge_function stub: answers D cycles after each strobe of dut_a (both DUTs
  // see the same answer), or never while stub_mute is set.
  int               stub_d = 3;
  bit               stub_mute = 1'b0;
  int               stub_cnt = 0;
  logic [31:0]      stub_res = 32'd0;
  int               strobe_total_a = 0;
  int               strobe_total_b = 0;
  logic [191:0]     rec [64];

  always @(posedge clk) begin : stub
    logic [31:0] res;
    ef_done <= 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        ef_done <= 1'b1;
        ef_z    <= stub_res;
      end
    end
    if (strobe_b) strobe_total_b <= strobe_total_b + 1;
    if (strobe_a) begin
      res = r2f(edge_e(efa_a, efb_a, efc_a));
      rec[strobe_total_a % 64] <= {efa_a, efb_a, efc_a};
      strobe_total_a <= strobe_total_a + 1;
      if (!stub_mute) begin
        if (stub_d <= 1) begin
          ef_done <= 1'b1;
          ef_z    <= res;
        end else begin
          stub_cnt <= stub_d - 1;
          stub_res <= res;
        end
      end
    end
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ops(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on both DUTs, checked against the model; a stray start is
  // poked mid-request and the vertex inputs are scrambled after acceptance.
  task automatic run_req(input string tag, input int d,
                         input logic [1:0][31:0] v0, v1, v2, p);
    real          ar, r0, r1, r2;
    bit           degen, nn, np, in_a, in_b;
    int           exp_lat, exp_st, cyc, st0, stb0;
    logic [191:0] exp_ops [4];
    ar = edge_e(v0, v1, v2);
    r0 = edge_e(v1, v2, p);
    r1 = edge_e(v2, v0, p);
    r2 = edge_e(v0, v1, p);
    degen   = (ar == 0.0);
    nn      = (r0 >= 0.0) && (r1 >= 0.0) && (r2 >= 0.0);
    np      = (r0 <= 0.0) && (r1 <= 0.0) && (r2 <= 0.0);
    in_a    = !degen && (ar > 0.0) && nn;
    in_b    = in_a || (!degen && (ar < 0.0) && np);
    exp_st  = degen ? 1 : 4;
    exp_lat = degen ? d + 2 : 4 * (d + 1) + 1;
    exp_ops[0] = {v0, v1, v2};
    exp_ops[1] = {v1, v2, p};
    exp_ops[2] = {v2, v0, p};
    exp_ops[3] = {v0, v1, p};
    stub_d = d;

    @(negedge clk);
    chk32({tag, ".ready"}, 32'(ready_a), 32'd1);
    st0  = strobe_total_a;
    stb0 = strobe_total_b;
    v0_i = v0; v1_i = v1; v2_i = v2; p_i = p;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    v0_i = {$urandom(), $urandom()};
    v1_i = {$urandom(), $urandom()};
    v2_i = {$urandom(), $urandom()};
    p_i  = {$urandom(), $urandom()};
    cyc = 1;
    while (!done_a && cyc < 400) begin
      start_i = (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;

    chk32({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
    chk32({tag, ".done_a"}, 32'(done_a), 32'd1);
    chk32({tag, ".done_b"}, 32'(done_b), 32'd1);
    chk32({tag, ".degenerate"}, 32'(degen_a), 32'(degen));
    chk32({tag, ".degenerate_b"}, 32'(degen_b), 32'(degen));
    chk32({tag, ".error"}, 32'(err_a), 32'd0);
    chk32({tag, ".error_b"}, 32'(err_b), 32'd0);
    chk32({tag, ".inside_a"}, 32'(inside_a), 32'(in_a));
    chk32({tag, ".inside_b"}, 32'(inside_b), 32'(in_b));
    chk32({tag, ".area"}, area_a, r2f(ar));
    chk32({tag, ".area_b"}, area_b, r2f(ar));
    if (!degen) begin
      chk32({tag, ".w0"}, w0_a, r2f(r0));
      chk32({tag, ".w1"}, w1_a, r2f(r1));
      chk32({tag, ".w2"}, w2_a, r2f(r2));
      chk32({tag, ".w0_b"}, w0_b, r2f(r0));
      chk32({tag, ".w1_b"}, w1_b, r2f(r1));
      chk32({tag, ".w2_b"}, w2_b, r2f(r2));
    end
    chk32({tag, ".strobes"}, 32'(strobe_total_a - st0), 32'(exp_st));
    chk32({tag, ".strobes_b"}, 32'(strobe_total_b - stb0), 32'(exp_st));
    for (int i = 0; i < exp_st; i++)
      chk_ops({tag, ".operands"}, rec[(st0 + i) % 64], exp_ops[i]);
    chk_ops({tag, ".operands_b"}, {efa_b, efb_b, efc_b}, exp_ops[exp_st - 1]);

    @(negedge clk);
    chk32({tag, ".done_pulse"}, 32'(done_a), 32'd0);
    chk32({tag, ".ready_after"}, 32'(ready_a), 32'd1);
    chk32({tag, ".ready_after_b"}, 32'(ready_b), 32'd1);
  endtask

  initial begin
    int  cyc;
    int  st0;
    bit  saw_done;

    // ---- reset state
    #1 reset_i = 1'b1;
    @(negedge clk);
    chk32("rst.ready", 32'(ready_a), 32'd1);
    chk32("rst.done", 32'(done_a), 32'd0);
    chk32("rst.strobe", 32'(strobe_a), 32'd0);
    chk32("rst.inside", 32'(inside_a), 32'd0);
    chk32("rst.area", area_a, 32'd0);
    chk_ops("rst.operands", {efa_a, efb_a, efc_a}, 192'd0);
    @(negedge clk);
    reset_i = 1'b0;

    // ---- covered pixel, D=3
    run_req("cov", 3, pt(Z, Z), pt(Z, ONE), pt(ONE, Z), pt(QTR, QTR));
    chk32("cov.area_const", area_a, ONE);
    chk32("cov.w0_const", w0_a, HALF);
    chk32("cov.w1_const", w1_a, QTR);
    chk32("cov.w2_const", w2_a, QTR);
    chk32("cov.inside_const", 32'(inside_a), 32'd1);

    // ---- outside pixel
    run_req("out", 3, pt(Z, Z), pt(Z, ONE), pt(ONE, Z), pt(ONE, ONE));
    chk32("out.w0_const", w0_a, 32'hbf800000);
    chk32("out.w1_const", w1_a, ONE);
    chk32("out.w2_const", w2_a, ONE);
    chk32("out.inside_const", 32'(inside_a), 32'd0);

    // ---- on-edge pixel
    run_req("edge", 2, pt(Z, Z), pt(Z, ONE), pt(ONE, Z), pt(Z, HALF));
    chk32("edge.w2_zero", w2_a & 32'h7fffffff, 32'd0);
    chk32("edge.w0_const", w0_a, HALF);
    chk32("edge.w1_const", w1_a, HALF);
    chk32("edge.inside_const", 32'(inside_a), 32'd1);

    // ---- degenerate triangle
    run_req("degen", 3, pt(Z, Z), pt(Z, ONE), pt(Z, TWO), pt(QTR, QTR));
    chk32("degen.area_zero", area_a & 32'h7fffffff, 32'd0);
    chk32("degen.flag_const", 32'(degen_a), 32'd1);
    chk32("degen.inside_const", 32'(inside_a), 32'd0);

    // ---- clockwise winding
    run_req("wind", 3, pt(Z, Z), pt(ONE, Z), pt(Z, ONE), pt(QTR, QTR));
    chk32("wind.area_const", area_a, 32'hbf800000);
    chk32("wind.inside_a_const", 32'(inside_a), 32'd0);
    chk32("wind.inside_b_const", 32'(inside_b), 32'd1);

    // ---- watchdog: datapath never answers, dut_a times out after 8 WAIT cycles
    stub_mute = 1'b1;
    @(negedge clk);
    st0 = strobe_total_a;
    v0_i = pt(Z, Z); v1_i = pt(Z, ONE); v2_i = pt(ONE, Z); p_i = pt(QTR, QTR);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    while (!done_a && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk32("tmo.done", 32'(done_a), 32'd1);
    chk32("tmo.latency", 32'(cyc), 32'd10);
    chk32("tmo.error", 32'(err_a), 32'd1);
    chk32("tmo.inside", 32'(inside_a), 32'd0);
    chk32("tmo.strobes", 32'(strobe_total_a - st0), 32'd1);
    @(negedge clk);
    chk32("tmo.done_pulse", 32'(done_a), 32'd0);
    chk32("tmo.ready", 32'(ready_a), 32'd1);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    stub_mute = 1'b0;

    // ---- reset pulsed while op2 is outstanding
    stub_d = 3;
    @(negedge clk);
    st0 = strobe_total_a;
    v0_i = pt(Z, Z); v1_i = pt(Z, ONE); v2_i = pt(ONE, Z); p_i = pt(QTR, QTR);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    while ((strobe_total_a - st0) < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk32("rmid.reached_op2", 32'(strobe_total_a - st0), 32'd3);
    reset_i = 1'b1;
    #1;
    chk32("rmid.ready", 32'(ready_a), 32'd1);
    chk32("rmid.done", 32'(done_a), 32'd0);
    chk32("rmid.strobe", 32'(strobe_a), 32'd0);
    chk32("rmid.flags", {29'd0, inside_a, degen_a, err_a}, 32'd0);
    chk32("rmid.area", area_a, 32'd0);
    chk32("rmid.w0", w0_a, 32'd0);
    chk32("rmid.w1", w1_a, 32'd0);
    chk32("rmid.w2", w2_a, 32'd0);
    chk_ops("rmid.operands", {efa_a, efb_a, efc_a}, 192'd0);
    @(negedge clk);
    reset_i = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_a || done_b) saw_done = 1'b1;
    end
    chk32("rmid.no_done", 32'(saw_done), 32'd0);
    chk32("rmid.no_more_strobes", 32'(strobe_total_a - st0), 32'd3);
    chk32("rmid.ready_after", 32'(ready_a), 32'd1);

    // ---- randomized triangles with integer coordinates in [-4,4]
    for (int i = 0; i < 40; i++) begin
      logic [1:0][31:0] rv [4];
      for (int j = 0; j < 4; j++)
        rv[j] = pt(r2f(real'(int'($urandom_range(0, 8)) - 4)),
                   r2f(real'(int'($urandom_range(0, 8)) - 4)));
      run_req("rnd", int'($urandom_range(1, 5)), rv[0], rv[1], rv[2], rv[3]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
